msgdma_desc_ctrl: RTL

MSGDMA_DESC_CTRL -- requirements
Module: msgdma_desc_ctrl

---
 rtl/msgdma_desc_ctrl_pkg.sv | 25 ++
 rtl/msgdma_desc_pack.sv | 29 ++
 rtl/msgdma_desc_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/msgdma_desc_ctrl_pkg.sv
// Shared types and descriptor layout for the mSGDMA descriptor controller.
// Field offsets follow the standard (non-extended) 128-bit mSGDMA descriptor.
package msgdma_desc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIELD_W     = 32;
  localparam int RD_ADDR_LSB = 0;
  localparam int WR_ADDR_LSB = 32;
  localparam int LEN_LSB     = 64;
  localparam int CTRL_LSB    = 96;

  localparam int CTRL_GO  = 31;
  localparam int CTRL_SOP = 8;
  localparam int CTRL_EOP = 9;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/msgdma_desc_pack.sv
// Formats descriptor fields into the 128-bit word written to the mSGDMA
// descriptor slave. Write address is unused on a memory-to-stream path.
module msgdma_desc_pack
  import msgdma_desc_ctrl_pkg::*;
(
  input  logic [31:0]  rd_addr,
  input  logic [31:0]  length,
  input  logic         sop,
  input  logic         eop,
  output logic [127:0] desc
);

  logic [31:0] ctrl;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    ctrl           = '0;
    ctrl[CTRL_GO]  = 1'b1;
    ctrl[CTRL_SOP] = sop;
    ctrl[CTRL_EOP] = eop;

    desc                           = '0;
    desc[RD_ADDR_LSB +: FIELD_W]   = rd_addr;
    desc[WR_ADDR_LSB +: FIELD_W]   = '0;
    desc[LEN_LSB     +: FIELD_W]   = length;
    desc[CTRL_LSB    +: FIELD_W]   = ctrl;
  end

endmodule

// File: rtl/msgdma_desc_ctrl.sv
// Splits a contiguous SDRAM read into chunked mSGDMA descriptors, throttled by
// a window of issued-but-unconsumed stream beats, and reports completion.
module msgdma_desc_ctrl
  import msgdma_desc_ctrl_pkg::*;
#(
  parameter int BEAT_BYTES   = 32,
  parameter int WINDOW_BEATS = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  base_addr,
  input  logic [31:0]  total_bytes,
  input  logic [31:0]  chunk_bytes,
  output logic         desc_write,
  output logic [127:0] desc_writedata,
  output logic [15:0]  desc_byteenable,
  input  logic         desc_waitrequest,
  input  logic         st_valid,
  input  logic         st_ready,
  output logic         busy,
  output logic         done,
  output logic         cfg_error
);

  localparam int          BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam logic [31:0] BEAT_MASK  = 32'(BEAT_BYTES - 1);

  state_t       state, next_state;
  logic [31:0]  cur_addr, remaining, chunk, total_beats;
  logic [31:0]  issued_beats, consumed_beats;
  logic         first_desc, abort_pending, write_q, done_q, cfg_error_q;
  logic [127:0] data_q;
  logic [15:0]  be_q;

  logic         cfg_ok, start_ok, accepted, last_desc, window_ok, issue_now, finish;
  logic [31:0]  len, len_beats;
  logic [127:0] packed_desc;

  assign cfg_ok    = (total_bytes != '0) && (chunk_bytes != '0) &&
                     (((base_addr | total_bytes | chunk_bytes) & BEAT_MASK) == '0);
  assign start_ok  = start && !abort;
  assign len       = min32(chunk, remaining);
  assign len_beats = len >> BEAT_SHIFT;
  assign last_desc = (len == remaining);
  assign window_ok = (issued_beats - consumed_beats + len_beats) <= 32'(WINDOW_BEATS);
  assign accepted  = write_q && !desc_waitrequest;
  assign issue_now = (state == ISSUE) && !write_q && !abort && window_ok;
  assign finish    = (state == DRAIN) && !abort && (consumed_beats == total_beats);

  msgdma_desc_pack u_pack (
    .rd_addr (cur_addr),
    .length  (len),
    .sop     (first_desc),
    .eop     (last_desc),
    .desc    (packed_desc)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_ok && cfg_ok) next_state = ISSUE;
      ISSUE: begin
        // A stalled write must complete before an abort can take effect.
        if (write_q) begin
          if (accepted)
            next_state = (abort || abort_pending) ? IDLE : (last_desc ? DRAIN : ISSUE);
        end else if (abort) begin
          next_state = IDLE;
        end
      end
      DRAIN: if (abort || consumed_beats == total_beats) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state != IDLE);
    desc_write      = write_q;
    desc_writedata  = data_q;
    desc_byteenable = be_q;
    done            = done_q;
    cfg_error       = cfg_error_q;
  end

  // NOTE: the descriptor data register is reset too, so nothing stale is visible after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr       <= '0;
      remaining      <= '0;
      chunk          <= '0;
      total_beats    <= '0;
      issued_beats   <= '0;
      consumed_beats <= '0;
      first_desc     <= 1'b0;
      abort_pending  <= 1'b0;
      write_q        <= 1'b0;
      data_q         <= '0;
      be_q           <= '0;
      done_q         <= 1'b0;
      cfg_error_q    <= 1'b0;
    end else begin
      done_q      <= finish;
      cfg_error_q <= (state == IDLE) && start_ok && !cfg_ok;

      if (state == IDLE) begin
        if (start_ok && cfg_ok) begin
          cur_addr       <= base_addr;
          remaining      <= total_bytes;
          chunk          <= chunk_bytes;
          total_beats    <= total_bytes >> BEAT_SHIFT;
          issued_beats   <= '0;
          consumed_beats <= '0;
          first_desc     <= 1'b1;
          abort_pending  <= 1'b0;
        end
      end else if (st_valid && st_ready) begin
        consumed_beats <= consumed_beats + 32'd1;
      end

      if (issue_now) begin
        write_q <= 1'b1;
        data_q  <= packed_desc;
        be_q    <= '1;
      end

      if ((state == ISSUE) && write_q && desc_waitrequest && abort)
        abort_pending <= 1'b1;

      if (accepted) begin
        write_q       <= 1'b0;
        be_q          <= '0;
        cur_addr      <= cur_addr + len;
        remaining     <= remaining - len;
        issued_beats  <= issued_beats + len_beats;
        first_desc    <= 1'b0;
        abort_pending <= 1'b0;
      end
    end
  end

endmodule
